// File: rtl/writeback_stage.sv
// writeback_stage: final RaptoRV pipeline stage. Retires one instruction per
// writeback-register load, extracts and extends load data, stalls upstream
// while a load response is outstanding, and counts retired instructions.
//
// Handshake: a transfer happens at a posedge where in_valid && in_ready.
// in_ready depends on the FSM state alone and never on in_valid. dmem_rvalid
// has no ready; it is consumed in the cycle it is high.
module writeback_stage #(
    parameter int COUNT_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_rd_we,
    input  logic [4:0]             in_rd_addr,
    input  logic                   in_is_load,
    input  logic [2:0]             in_load_funct3,
    input  logic [1:0]             in_addr_low,
    input  logic [31:0]            in_result,
    input  logic                   dmem_rvalid,
    input  logic [31:0]            dmem_rdata,
    output logic                   rd_we,
    output logic [4:0]             rd_addr,
    output logic [31:0]            rd_data,
    output logic                   load_pending,
    output logic [4:0]             load_pending_addr,
    output logic [COUNT_WIDTH-1:0] retired_count,
    output logic                   error,
    output logic                   state_dbg
);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    state_t      state;
    logic [4:0]  p_addr;
    logic [2:0]  p_funct3;
    logic [1:0]  p_addr_low;
    logic        p_we;

    logic        accept;
    logic [2:0]  ext_funct3;
    logic [1:0]  ext_addr_low;
    logic [7:0]  ext_byte;
    logic [15:0] ext_half;
    logic [31:0] ext_data;
    logic        ext_bad;

    assign in_ready          = (state == IDLE);
    assign accept            = in_valid && in_ready;
    assign load_pending      = (state == WAIT_LOAD);
    assign load_pending_addr = (state == WAIT_LOAD) ? p_addr : 5'd0;
    assign state_dbg         = state;

    // Extract load data; the incoming load drives the controls in IDLE, the captured load in WAIT_LOAD.
    always_comb begin
        ext_funct3   = (state == IDLE) ? in_load_funct3 : p_funct3;
        ext_addr_low = (state == IDLE) ? in_addr_low : p_addr_low;
        case (ext_addr_low)
            2'd0:    ext_byte = dmem_rdata[7:0];
            2'd1:    ext_byte = dmem_rdata[15:8];
            2'd2:    ext_byte = dmem_rdata[23:16];
            default: ext_byte = dmem_rdata[31:24];
        endcase
        // Halfword selection ignores addr_low[0].
        ext_half = ext_addr_low[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        ext_bad  = 1'b0;
        case (ext_funct3)
            3'd0: ext_data = {{24{ext_byte[7]}}, ext_byte};
            3'd1: ext_data = {{16{ext_half[15]}}, ext_half};
            3'd2: ext_data = dmem_rdata;
            3'd4: ext_data = {24'd0, ext_byte};
            3'd5: ext_data = {16'd0, ext_half};
            default: begin
                // Undefined load types behave as LW but are flagged.
                ext_data = dmem_rdata;
                ext_bad  = 1'b1;
            end
        endcase
    end

    // FSM, writeback register, pending-load capture, retire counter and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            p_addr        <= 5'd0;
            p_funct3      <= 3'd0;
            p_addr_low    <= 2'd0;
            p_we          <= 1'b0;
            rd_we         <= 1'b0;
            rd_addr       <= 5'd0;
            rd_data       <= 32'd0;
            retired_count <= '0;
            error         <= 1'b0;
        end else begin
            rd_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && !in_is_load) begin
                        rd_we         <= in_rd_we && (in_rd_addr != 5'd0);
                        rd_addr       <= in_rd_addr;
                        rd_data       <= in_result;
                        retired_count <= retired_count + COUNT_WIDTH'(1);
                        // A response arriving with a non-load has no load to belong to.
                        if (dmem_rvalid) error <= 1'b1;
                    end else if (accept && dmem_rvalid) begin
                        rd_we         <= in_rd_we && (in_rd_addr != 5'd0);
                        rd_addr       <= in_rd_addr;
                        rd_data       <= ext_data;
                        retired_count <= retired_count + COUNT_WIDTH'(1);
                        if (ext_bad) error <= 1'b1;
                    end else if (accept) begin
                        p_addr     <= in_rd_addr;
                        p_funct3   <= in_load_funct3;
                        p_addr_low <= in_addr_low;
                        p_we       <= in_rd_we;
                        state      <= WAIT_LOAD;
                    end else if (dmem_rvalid) begin
                        error <= 1'b1;
                    end
                end
                WAIT_LOAD: begin
                    if (dmem_rvalid) begin
                        rd_we         <= p_we && (p_addr != 5'd0);
                        rd_addr       <= p_addr;
                        rd_data       <= ext_data;
                        retired_count <= retired_count + COUNT_WIDTH'(1);
                        if (ext_bad) error <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: table-driven and scoreboard bench for writeback_stage.
module tb_writeback_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_rd_we;
    logic [4:0]  in_rd_addr;
    logic        in_is_load;
    logic [2:0]  in_load_funct3;
    logic [1:0]  in_addr_low;
    logic [31:0] in_result;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        load_pending;
    logic [4:0]  load_pending_addr;
    logic [63:0] retired_count;
    logic        error;
    logic        state_dbg;

    logic        n_in_ready, n_rd_we, n_load_pending, n_error, n_state_dbg;
    logic [4:0]  n_rd_addr, n_load_pending_addr;
    logic [31:0] n_rd_data;
    logic [3:0]  n_retired_count;

    int tests = 0;
    int fails = 0;
    int n_pushed = 0;
    logic [37:0] exp_q[$];
    logic [63:0] prev_cnt = '0;
    logic [31:0] rf[32];

    writeback_stage #(.COUNT_WIDTH(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd_we(in_rd_we), .in_rd_addr(in_rd_addr), .in_is_load(in_is_load),
        .in_load_funct3(in_load_funct3), .in_addr_low(in_addr_low), .in_result(in_result),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
        .load_pending(load_pending), .load_pending_addr(load_pending_addr),
        .retired_count(retired_count), .error(error), .state_dbg(state_dbg)
    );

    writeback_stage #(.COUNT_WIDTH(4)) dut_narrow (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
        .in_rd_we(in_rd_we), .in_rd_addr(in_rd_addr), .in_is_load(in_is_load),
        .in_load_funct3(in_load_funct3), .in_addr_low(in_addr_low), .in_result(in_result),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .rd_we(n_rd_we), .rd_addr(n_rd_addr), .rd_data(n_rd_data),
        .load_pending(n_load_pending), .load_pending_addr(n_load_pending_addr),
        .retired_count(n_retired_count), .error(n_error), .state_dbg(n_state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, act=running req=finished");
        $fatal(1, "timeout");
    end

    // Register file model fed by the write port
    always @(posedge clk) begin
        if (rd_we) rf[rd_addr] <= rd_data;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: act=0x%0h req=0x%0h", name, act, req);
        end
    endtask

    // Scoreboard: every retirement (count step or write pulse) pops one expectation
    always @(negedge clk) begin
        if (!rst && (retired_count != prev_cnt || rd_we)) begin
            check("retire_step", retired_count - prev_cnt, 64'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_retire", {rd_we, rd_addr, rd_data}, 38'd0);
            end else begin
                check("writeback", {26'd0, rd_we, rd_addr, rd_data}, {26'd0, exp_q.pop_front()});
            end
        end
        prev_cnt = retired_count;
    end

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic        ld;
        logic [2:0]  f3;
        logic [1:0]  alow;
        logic [31:0] res;
        logic [31:0] rdata;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
    } vec_t;

    function automatic logic [31:0] model_ext(input logic [2:0] f3, input logic [1:0] alow,
                                              input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = w >> (alow * 8);
        h = w >> (alow[1] ? 16 : 0);
        case (f3)
            3'd0: return {{24{b[7]}}, b[7:0]};
            3'd1: return {{16{h[15]}}, h[15:0]};
            3'd4: return b & 32'hFF;
            3'd5: return h & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    task automatic idle_inputs();
        in_valid = 1'b0; in_rd_we = 1'b0; in_rd_addr = 5'd0; in_is_load = 1'b0;
        in_load_funct3 = 3'd0; in_addr_low = 2'd0; in_result = 32'd0;
        dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        n_pushed = 0;
    endtask

    // Present one instruction for one cycle; expectation is queued at drive time.
    task automatic issue(input vec_t v, input logic rv, input logic push);
        check("ready_at_issue", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1; in_rd_we = v.we; in_rd_addr = v.addr; in_is_load = v.ld;
        in_load_funct3 = v.f3; in_addr_low = v.alow; in_result = v.res;
        dmem_rvalid = rv; dmem_rdata = v.rdata;
        if (push) begin
            exp_q.push_back({v.e_we, v.e_addr, v.e_data});
            n_pushed++;
        end
        @(posedge clk);
        #1 idle_inputs();
    endtask

    task automatic drain();
        repeat (2) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("count_total", retired_count, 64'(n_pushed));
    endtask

    vec_t vecs[11];
    vec_t v;
    logic [2:0] good_f3[5];

    initial begin
        good_f3[0] = 3'd0; good_f3[1] = 3'd1; good_f3[2] = 3'd2; good_f3[3] = 3'd4; good_f3[4] = 3'd5;
        vecs[0]  = '{1'b1, 5'd5,  1'b0, 3'd0, 2'd0, 32'hDEADBEEF, 32'h0,        1'b1, 5'd5,  32'hDEADBEEF};
        vecs[1]  = '{1'b1, 5'd0,  1'b0, 3'd0, 2'd0, 32'h12345678, 32'h0,        1'b0, 5'd0,  32'h12345678};
        vecs[2]  = '{1'b1, 5'd1,  1'b1, 3'd0, 2'd3, 32'h0,        32'h80F17F01, 1'b1, 5'd1,  32'hFFFFFF80};
        vecs[3]  = '{1'b1, 5'd2,  1'b1, 3'd4, 2'd2, 32'h0,        32'h80F17F01, 1'b1, 5'd2,  32'h000000F1};
        vecs[4]  = '{1'b1, 5'd3,  1'b1, 3'd1, 2'd2, 32'h0,        32'h80F17F01, 1'b1, 5'd3,  32'hFFFF80F1};
        vecs[5]  = '{1'b1, 5'd4,  1'b1, 3'd5, 2'd0, 32'h0,        32'h80F17F01, 1'b1, 5'd4,  32'h00007F01};
        vecs[6]  = '{1'b1, 5'd6,  1'b1, 3'd2, 2'd1, 32'h0,        32'h80F17F01, 1'b1, 5'd6,  32'h80F17F01};
        vecs[7]  = '{1'b1, 5'd8,  1'b1, 3'd1, 2'd3, 32'h0,        32'h80F17F01, 1'b1, 5'd8,  32'hFFFF80F1};
        vecs[8]  = '{1'b1, 5'd9,  1'b1, 3'd5, 2'd1, 32'h0,        32'h80F17F01, 1'b1, 5'd9,  32'h00007F01};
        vecs[9]  = '{1'b1, 5'd10, 1'b1, 3'd0, 2'd0, 32'h0,        32'h80F17F01, 1'b1, 5'd10, 32'h00000001};
        vecs[10] = '{1'b0, 5'd11, 1'b1, 3'd4, 2'd3, 32'h0,        32'h80F17F01, 1'b0, 5'd11, 32'h00000080};

        // Reset values
        do_reset();
        @(negedge clk);
        check("rst_rd_we", {63'd0, rd_we}, 64'd0);
        check("rst_rd_addr", {59'd0, rd_addr}, 64'd0);
        check("rst_rd_data", {32'd0, rd_data}, 64'd0);
        check("rst_count", retired_count, 64'd0);
        check("rst_error", {63'd0, error}, 64'd0);
        check("rst_pending", {63'd0, load_pending}, 64'd0);
        check("rst_pending_addr", {59'd0, load_pending_addr}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;

        // Table vectors, back to back
        for (int i = 0; i < 11; i++) issue(vecs[i], vecs[i].ld, 1'b1);
        drain();
        check("rf_x5", {32'd0, rf[5]}, 64'h0000_0000_DEADBEEF);
        check("no_error_table", {63'd0, error}, 64'd0);

        // Delayed load: LW to x7, response three cycles after acceptance
        v = '{1'b1, 5'd7, 1'b1, 3'd2, 2'd0, 32'h0, 32'h0, 1'b1, 5'd7, 32'hCAFEF00D};
        issue(v, 1'b0, 1'b0);
        in_valid = 1'b1; in_rd_we = 1'b1; in_rd_addr = 5'd12; in_result = 32'hA5A5_5A5A;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("wait_in_ready", {63'd0, in_ready}, 64'd0);
            check("wait_pending", {63'd0, load_pending}, 64'd1);
            check("wait_pending_addr", {59'd0, load_pending_addr}, 64'd7);
            if (c == 2) begin
                dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
                exp_q.push_back({1'b1, 5'd7, 32'hCAFEF00D});
                exp_q.push_back({1'b1, 5'd12, 32'hA5A5_5A5A});
                n_pushed += 2;
            end
        end
        @(posedge clk); #1 dmem_rvalid = 1'b0;
        @(negedge clk);
        check("after_load_pending", {63'd0, load_pending}, 64'd0);
        check("after_load_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1 idle_inputs();
        drain();
        check("rf_x7", {32'd0, rf[7]}, 64'h0000_0000_CAFEF00D);

        // Random non-loads and same-cycle loads with random gaps
        for (int i = 0; i < 40; i++) begin
            v.we = 1'($urandom_range(0, 1));
            v.addr = 5'($urandom_range(0, 31));
            v.ld = 1'($urandom_range(0, 1));
            v.f3 = good_f3[$urandom_range(0, 4)];
            v.alow = 2'($urandom_range(0, 3));
            v.res = $urandom;
            v.rdata = $urandom;
            v.e_we = v.we && (v.addr != 5'd0);
            v.e_addr = v.addr;
            v.e_data = v.ld ? model_ext(v.f3, v.alow, v.rdata) : v.res;
            issue(v, v.ld, 1'b1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain();
        check("no_error_random", {63'd0, error}, 64'd0);

        // Stray response in IDLE sets the sticky error
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1;
        @(posedge clk); #1 dmem_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_rvalid_error", {63'd0, error}, 64'd1);
        check("stray_rvalid_no_write", {63'd0, rd_we}, 64'd0);

        // Undefined funct3 behaves as LW and flags error
        do_reset();
        @(negedge clk);
        check("error_cleared", {63'd0, error}, 64'd0);
        @(posedge clk); #1;
        v = '{1'b1, 5'd13, 1'b1, 3'd7, 2'd1, 32'h0, 32'h80F17F01, 1'b1, 5'd13, 32'h80F17F01};
        issue(v, 1'b1, 1'b1);
        drain();
        check("funct3_error", {63'd0, error}, 64'd1);

        // Reset in WAIT_LOAD drops the load; later response flags error
        do_reset();
        @(posedge clk); #1;
        v = '{1'b1, 5'd3, 1'b1, 3'd2, 2'd0, 32'h0, 32'h0, 1'b1, 5'd3, 32'h0};
        issue(v, 1'b0, 1'b0);
        @(negedge clk);
        check("pre_rst_pending", {63'd0, load_pending}, 64'd1);
        #2 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
        @(posedge clk); #1 dmem_rvalid = 1'b0;
        @(negedge clk);
        check("rst_wait_no_write", {63'd0, rd_we}, 64'd0);
        check("rst_wait_error", {63'd0, error}, 64'd1);
        check("rst_wait_count", retired_count, 64'd0);
        check("rst_wait_pending", {63'd0, load_pending}, 64'd0);

        // Counter wrap on the narrow instance
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 17; i++) begin
            v = '{1'b1, 5'(i + 1), 1'b0, 3'd0, 2'd0, 32'(i * 3), 32'h0, 1'b1, 5'(i + 1), 32'(i * 3)};
            issue(v, 1'b0, 1'b1);
        end
        drain();
        check("wrap_narrow_count", {60'd0, n_retired_count}, 64'd1);
        check("wide_count_17", retired_count, 64'd17);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
